// File: rtl/hazard_forward_ctrl.sv
// Forward/hazard controller beside Decode: tracks in-flight destination registers,
// drives registered operand-forward selects, load-use stall/bubble and jump flush.
module hazard_forward_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_valid_ip,
  input  logic [4:0]       id_rs1_addr_ip,
  input  logic             id_rs1_used_ip,
  input  logic [4:0]       id_rs2_addr_ip,
  input  logic             id_rs2_used_ip,
  input  logic [4:0]       id_rd_addr_ip,
  input  logic             id_reg_write_ip,
  input  logic             id_is_load_ip,
  input  logic             flush_req_ip,
  output logic [1:0]       fa_mux_op,
  output logic [1:0]       fb_mux_op,
  output logic             stall_op,
  output logic             bubble_op,
  output logic             flush_op,
  output logic [CNT_W-1:0] stall_count_op,
  output logic [CNT_W-1:0] flush_count_op
);

  localparam logic [1:0] FWD_DEFAULT       = 2'b00;
  localparam logic [1:0] EX_RESULT_SELECT  = 2'b01;
  localparam logic [1:0] MEM_RESULT_SELECT = 2'b10;
  localparam logic [2:0] FLUSH_RELOAD      = 3'(FLUSH_CYCLES - 1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t     state;
  logic [2:0] flush_left;

  // The WB slot is not kept: nothing forwards from it, since the register file
  // writes through to Decode. MEM needs no is_load bit for the same reason.
  logic       ex_vld, mem_vld;
  logic [4:0] ex_rd, mem_rd;
  logic       ex_ld;

  logic       id_writes;
  logic       load_use;
  logic       insert_nop;
  logic [1:0] fa_nxt, fb_nxt;

  function automatic logic [1:0] fwd_sel(input logic used, input logic [4:0] rs,
                                         input logic e_vld, input logic [4:0] e_rd,
                                         input logic m_vld, input logic [4:0] m_rd);
    logic [1:0] sel;
    sel = FWD_DEFAULT;
    if (used && e_vld && (e_rd == rs))
      sel = EX_RESULT_SELECT;
    else if (used && m_vld && (m_rd == rs))
      sel = MEM_RESULT_SELECT;
    return sel;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Slot valid already implies rd != 0, so x0 can never match a producer.
  assign id_writes = id_valid_ip && id_reg_write_ip && (id_rd_addr_ip != 5'd0);
  assign load_use  = id_valid_ip && ex_vld && ex_ld &&
                     ((id_rs1_used_ip && (id_rs1_addr_ip == ex_rd)) ||
                      (id_rs2_used_ip && (id_rs2_addr_ip == ex_rd)));

  assign flush_op   = (state == FLUSH) || flush_req_ip;
  assign stall_op   = load_use && !flush_op;
  assign bubble_op  = stall_op;
  assign insert_nop = bubble_op || flush_op;

  assign fa_nxt = insert_nop ? FWD_DEFAULT :
                  fwd_sel(id_rs1_used_ip, id_rs1_addr_ip, ex_vld, ex_rd, mem_vld, mem_rd);
  assign fb_nxt = insert_nop ? FWD_DEFAULT :
                  fwd_sel(id_rs2_used_ip, id_rs2_addr_ip, ex_vld, ex_rd, mem_vld, mem_rd);

  // Stage boundary ID -> EX -> MEM: control state, selects and counters
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= RUN;
      flush_left     <= 3'd0;
      ex_vld         <= 1'b0;
      mem_vld        <= 1'b0;
      fa_mux_op      <= FWD_DEFAULT;
      fb_mux_op      <= FWD_DEFAULT;
      stall_count_op <= '0;
      flush_count_op <= '0;
    end else begin
      mem_vld   <= ex_vld;
      ex_vld    <= insert_nop ? 1'b0 : id_writes;
      fa_mux_op <= fa_nxt;
      fb_mux_op <= fb_nxt;
      if (stall_op)
        stall_count_op <= sat_inc(stall_count_op);
      if (flush_req_ip)
        flush_count_op <= sat_inc(flush_count_op);
      case (state)
        RUN: begin
          if (flush_req_ip && (FLUSH_CYCLES > 1)) begin
            state      <= FLUSH;
            flush_left <= FLUSH_RELOAD;
          end
        end
        FLUSH: begin
          if (flush_req_ip)
            flush_left <= FLUSH_RELOAD;
          else if (flush_left <= 3'd1)
            state <= RUN;
          else
            flush_left <= flush_left - 3'd1;
        end
        default: state <= RUN;
      endcase
    end
  end

  // Slot payload travels without reset; only the valid bits qualify it.
  always_ff @(posedge clock) begin
    mem_rd <= ex_rd;
    ex_rd  <= id_rd_addr_ip;
    ex_ld  <= id_is_load_ip;
  end

endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
- Forward/hazard controller for the 5-stage RISC-V core; it sits beside Decode and drives the operand-forward selects consumed by the Execute stage.
- It tracks destination registers of in-flight instructions in a shadow pipeline (EX, MEM, WB slots).
- From those slots it generates registered forward selects, load-use stall/bubble, and a multi-cycle flush after a jump resolves in Execute.
- It keeps saturating stall and flush performance counters.

Parameters:
FLUSH_CYCLES, 2, cycles flush_op stays high per flush request (legal 1..7)
CNT_W, 32, width of performance counters

Ports:
clock  in  1  core clock
reset  in  1  synchronous, active-high reset
id_valid_ip  in  1  valid instruction in Decode
id_rs1_addr_ip  in  5  Decode source register 1
id_rs1_used_ip  in  1  instruction reads rs1
id_rs2_addr_ip  in  5  Decode source register 2
id_rs2_used_ip  in  1  instruction reads rs2
id_rd_addr_ip  in  5  Decode destination register
id_reg_write_ip  in  1  instruction writes rd
id_is_load_ip  in  1  instruction is a load
flush_req_ip  in  1  jump taken in Execute (flush_en_op AND next_PC_addr_valid_op)
fa_mux_op  out  forward_mux_code  rs1 select for the instruction in EX
fb_mux_op  out  forward_mux_code  rs2 select for the instruction in EX
stall_op  out  1  hold PC and IF/ID this cycle
bubble_op  out  1  load NOP into ID/EX this cycle
flush_op  out  1  squash IF/ID and ID/EX this cycle
stall_count_op  out  CNT_W  load-use stall cycles
flush_count_op  out  CNT_W  accepted flush requests

Behaviour:
- Interface: one clock, `clock`. `reset` is synchronous and active-high.
- Reset values:
  - fa_mux_op and fb_mux_op = default (no-forward) code.
  - All slots invalid; FSM in RUN.
  - Counters = 0; stall_op, bubble_op and flush_op = 0.
- Slot contents: each of the EX, MEM and WB slots holds {valid, rd, is_load}.
- Slot shift on every posedge:
  - wb <= mem; mem <= ex.
  - ex <= Decode instruction, or invalid when bubble_op or flush_op is high.
  - valid = id_valid_ip AND id_reg_write_ip AND rd != 0.
- Forward select per source, evaluated against pre-edge slots and registered into fa_mux_op/fb_mux_op at the same edge the ID/EX buffer captures the instruction:
  - If source used and ex slot valid and rd match: EX_RESULT_SELECT.
  - Else if mem slot valid and rd match: MEM_RESULT_SELECT.
  - Else: default.
  - EX-slot match has priority over MEM-slot match (youngest producer wins).
  - Register x0 is never forwarded.
  - When bubble or flush is inserted, both registered selects = default.
- Load-use hazard (combinational, RUN only):
  - Condition: id_valid_ip AND ex slot valid AND ex.is_load AND a used source matches ex.rd.
  - Effect: stall_op = 1 and bubble_op = 1 for exactly one cycle.
  - Next cycle the load sits in MEM, the consumer re-evaluates and takes MEM_RESULT_SELECT.
- FSM states: RUN, FLUSH.
  - RUN + flush_req_ip: flush_op = 1 that cycle.
    - FLUSH_CYCLES > 1: go to FLUSH, counter = FLUSH_CYCLES-1.
    - FLUSH_CYCLES = 1: stay in RUN.
  - FLUSH: flush_op = 1; counter decrements each cycle; return to RUN after the cycle where counter reaches 1.
  - flush_req_ip while in FLUSH reloads the counter to FLUSH_CYCLES-1 and counts again.
- Priority: flush over stall. While flush_op = 1, stall_op = 0 and bubble_op = 0, and id inputs are ignored.
- Counters:
  - stall_count_op increments on each stall_op cycle.
  - flush_count_op increments on each cycle flush_req_ip = 1.
  - Both saturate at all-ones.
- Reset mid-flush or mid-stall: next cycle is RUN, slots invalid, all outputs at reset values.

Test Plan:
- Back-to-back ALU: add x5 then sub x6,x5,x1 -> cycle sub enters EX: fa_mux_op = EX_RESULT_SELECT, fb_mux_op = default, stall_op = 0.
- Distance-2 plus double match: x5 written two instructions earlier and x5 also written by the previous instruction -> consumer gets EX_RESULT_SELECT. With only the distance-2 producer -> MEM_RESULT_SELECT.
- Load-use: lw x7 then add x8,x7,x7 -> exactly one cycle of stall_op = bubble_op = 1. Add then enters EX with fa_mux_op = fb_mux_op = MEM_RESULT_SELECT; stall_count_op = 1.
- x0 / non-writers: producer rd = 0, or id_reg_write_ip = 0 with matching rd -> selects stay default; no stall after lw x0.
- Flush with FLUSH_CYCLES = 2:
  - flush_req_ip pulse -> flush_op high 2 cycles.
  - A load-use hazard present during the flush -> stall_op = 0.
  - Second req in cycle 2 -> flush_op extends to 3 cycles; flush_count_op = 2.
- Reset asserted during FLUSH with a pending stall -> next cycle all outputs zero/default and counters = 0; the first following instruction sees no forwarding.
